// File: rtl/fp_class_pipe_pkg.sv
// Shared FPU classify types: operand/result bundles, decoded field
// flags and the RISC-V FCLASS mask bit positions.
package fp_wire;

    localparam int unsigned FP_TAG_W = 5;
    localparam int unsigned FCLASS_W = 10;

    localparam int unsigned FCLASS_NINF  = 0;
    localparam int unsigned FCLASS_NNORM = 1;
    localparam int unsigned FCLASS_NSUB  = 2;
    localparam int unsigned FCLASS_NZERO = 3;
    localparam int unsigned FCLASS_PZERO = 4;
    localparam int unsigned FCLASS_PSUB  = 5;
    localparam int unsigned FCLASS_PNORM = 6;
    localparam int unsigned FCLASS_PINF  = 7;
    localparam int unsigned FCLASS_SNAN  = 8;
    localparam int unsigned FCLASS_QNAN  = 9;

    typedef struct packed {
        logic [31:0]         data;
        logic [1:0]          fmt;
        logic [FP_TAG_W-1:0] tag;
    } fp_class_in_type;

    typedef struct packed {
        logic [31:0]         result;
        logic [FP_TAG_W-1:0] tag;
    } fp_class_out_type;

    typedef struct packed {
        logic sign;
        logic exp_ones;
        logic exp_zero;
        logic man_zero;
        logic qbit;
        logic fmt_ok;
    } fp_class_fields_type;

    // Reduce a single-precision operand to the flags the classifier needs.
    function automatic fp_class_fields_type fp_class_extract(
        input logic [31:0] data,
        input logic [1:0]  fmt
    );
        fp_class_fields_type f;
        f.sign     = data[31];
        f.exp_ones = (data[30:23] == 8'hFF);
        f.exp_zero = (data[30:23] == 8'h00);
        f.man_zero = (data[22:0] == 23'h0);
        f.qbit     = data[22];
        f.fmt_ok   = (fmt == 2'b00);
        return f;
    endfunction

endpackage

// File: rtl/fp_class_pipe_if.sv
// Operand-in / result-out handshake bundle for the classify pipe.
interface fp_class_pipe_if #(
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      data;
    logic [1:0]       fmt;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  in_valid, data, fmt, tag_i, out_ready,
        output in_ready, out_valid, result, tag_o
    );

    modport master (
        output in_valid, data, fmt, tag_i, out_ready,
        input  in_ready, out_valid, result, tag_o
    );
endinterface

// File: rtl/fp_class_decode.sv
// Combinational FCLASS mask builder from pre-decoded operand flags.
module fp_class_decode
    import fp_wire::*;
(
    input  fp_class_fields_type  fields_i,
    output logic [FCLASS_W-1:0]  mask_o
);

    logic s, eo, ez, mz;

    assign s  = fields_i.sign;
    assign eo = fields_i.exp_ones;
    assign ez = fields_i.exp_zero;
    assign mz = fields_i.man_zero;

    // One-hot class select; unsupported formats give an all-zero mask.
    always_comb begin
        mask_o = '0;
        if (fields_i.fmt_ok) begin
            mask_o[FCLASS_NINF]  =  s & eo & mz;
            mask_o[FCLASS_NNORM] =  s & !eo & !ez;
            mask_o[FCLASS_NSUB]  =  s & ez & !mz;
            mask_o[FCLASS_NZERO] =  s & ez & mz;
            mask_o[FCLASS_PZERO] = !s & ez & mz;
            mask_o[FCLASS_PSUB]  = !s & ez & !mz;
            mask_o[FCLASS_PNORM] = !s & !eo & !ez;
            mask_o[FCLASS_PINF]  = !s & eo & mz;
            mask_o[FCLASS_SNAN]  = eo & !mz & !fields_i.qbit;
            mask_o[FCLASS_QNAN]  = eo & fields_i.qbit;
        end
    end

endmodule

// File: rtl/fp_class_pipe.sv
// Two-stage FCLASS.S pipeline: stage 1 captures field flags, stage 2
// holds the class mask. Valid/ready on both sides, synchronous flush.
module fp_class_pipe
    import fp_wire::*;
#(
    parameter int unsigned TAG_W = 5
)(
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    fp_class_pipe_if.slave bus
);

    logic                s1_valid_q, s1_valid_d;
    fp_class_fields_type s1_fields_q, s1_fields_d;
    logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;

    logic                s2_valid_q, s2_valid_d;
    logic [31:0]         s2_result_q, s2_result_d;
    logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;

    logic                s2_adv, s1_adv, in_ready, s1_load;
    logic [FCLASS_W-1:0] mask;

    fp_class_decode u_decode (
        .fields_i (s1_fields_q),
        .mask_o   (mask)
    );

    assign s2_adv   = !s2_valid_q | bus.out_ready;
    assign s1_adv   = s1_valid_q & s2_adv;
    assign in_ready = !flush & (!s1_valid_q | s2_adv);
    assign s1_load  = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = s2_result_q;
    assign bus.tag_o     = s2_tag_q;

    // Next-state for both stages; data only moves on a valid advance.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_fields_d = s1_fields_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            s2_result_d = {{(32-FCLASS_W){1'b0}}, mask};
            s2_tag_d    = s1_tag_q;
        end

        if (s1_load) begin
            s1_valid_d  = 1'b1;
            s1_fields_d = fp_class_extract(bus.data, bus.fmt);
            s1_tag_d    = bus.tag_i;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline state registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_fields_q <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fields_q <= s1_fields_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

endmodule

// File: tb/tb_fp_class_pipe.sv
// Directed bench for fp_class_pipe: classes, format gating, stall,
// simultaneous shift, flush and mid-stream reset.
module tb_fp_class_pipe;

    logic clock;
    logic reset;
    logic flush;
    int   checks;
    int   passed;

    fp_class_pipe_if #(.TAG_W(5)) bus ();

    fp_class_pipe #(.TAG_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.result !== 32'h0) $display("FAIL rst_result got %h want 00000000", bus.result); else passed++;
        checks++; if (bus.tag_o !== 5'd0) $display("FAIL rst_tag got %0d want 0", bus.tag_o); else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else passed++;
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_classes();
        logic [31:0] vec [10];
        logic [31:0] exp [10];
        vec = '{32'hFF800000, 32'hBF800000, 32'h807FFFFF, 32'h80000000, 32'h00000000,
                32'h00000001, 32'h3F800000, 32'h7F800000, 32'h7F800001, 32'hFFC00000};
        exp = '{32'h001, 32'h002, 32'h004, 32'h008, 32'h010,
                32'h020, 32'h040, 32'h080, 32'h100, 32'h200};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                bus.in_valid = 1'b1;
                bus.data     = vec[i];
                bus.fmt      = 2'd0;
                bus.tag_i    = 5'(i);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clock);
            checks++; if (bus.in_ready !== 1'b1) $display("FAIL cls_in_ready[%0d] got %b want 1", i, bus.in_ready); else passed++;
            if (i >= 2) begin
                checks++; if (bus.out_valid !== 1'b1) $display("FAIL cls_out_valid[%0d] got %b want 1", i, bus.out_valid); else passed++;
                checks++; if (bus.result !== exp[i-2]) $display("FAIL cls_result[%0d] got %h want %h", i-2, bus.result, exp[i-2]); else passed++;
                checks++; if (bus.tag_o !== 5'(i-2)) $display("FAIL cls_tag[%0d] got %0d want %0d", i-2, bus.tag_o, i-2); else passed++;
            end else begin
                checks++; if (bus.out_valid !== 1'b0) $display("FAIL cls_latency[%0d] got out_valid %b want 0", i, bus.out_valid); else passed++;
            end
            next_cycle();
        end
    endtask

    task automatic test_fmt();
        drain();
        bus.in_valid = 1'b1;
        bus.data     = 32'h3F800000;
        bus.fmt      = 2'd1;
        bus.tag_i    = 5'd7;
        next_cycle();
        bus.in_valid = 1'b0;
        bus.fmt      = 2'd0;
        next_cycle();
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL fmt_out_valid got %b want 1", bus.out_valid); else passed++;
        checks++; if (bus.result !== 32'h0) $display("FAIL fmt_result got %h want 00000000", bus.result); else passed++;
        checks++; if (bus.tag_o !== 5'd7) $display("FAIL fmt_tag got %0d want 7", bus.tag_o); else passed++;
        next_cycle();
    endtask

    task automatic test_back_pressure();
        logic [31:0] bp_data [4];
        logic [31:0] bp_exp [4];
        int sent;
        int got;
        logic accept;
        bp_data = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7FC00000};
        bp_exp  = '{32'h040, 32'h002, 32'h010, 32'h200};
        sent = 0;
        got  = 0;
        drain();
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            bus.out_ready = !(cyc >= 2 && cyc < 7);
            bus.in_valid  = (sent < 4);
            bus.data      = bp_data[(sent < 4) ? sent : 3];
            bus.fmt       = 2'd0;
            bus.tag_i     = 5'(sent + 1);
            @(negedge clock);
            if (cyc >= 2 && cyc < 7) begin
                checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_stall[%0d] got %b want 0", cyc, bus.in_ready); else passed++;
                checks++; if (bus.result !== bp_exp[0]) $display("FAIL bp_result_stable[%0d] got %h want %h", cyc, bus.result, bp_exp[0]); else passed++;
                checks++; if (bus.tag_o !== 5'd1) $display("FAIL bp_tag_stable[%0d] got %0d want 1", cyc, bus.tag_o); else passed++;
            end
            if (cyc >= 7 && cyc <= 10) begin
                checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_gap[%0d] got out_valid %b want 1", cyc, bus.out_valid); else passed++;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++; if (bus.tag_o !== 5'(got + 1)) $display("FAIL bp_order[%0d] got tag %0d want %0d", got, bus.tag_o, got + 1); else passed++;
                checks++; if (bus.result !== bp_exp[got]) $display("FAIL bp_data[%0d] got %h want %h", got, bus.result, bp_exp[got]); else passed++;
                got++;
            end
            accept = bus.in_valid && bus.in_ready;
            next_cycle();
            if (accept) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (got !== 4) $display("FAIL bp_count got %0d results want 4", got); else passed++;
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_duplicate got out_valid %b want 0", bus.out_valid); else passed++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drain();
        bus.out_ready = 1'b0;
        bus.fmt       = 2'd0;
        bus.in_valid  = 1'b1;
        bus.data      = 32'hFF800000;
        bus.tag_i     = 5'd10;
        next_cycle();
        bus.data      = 32'h80000000;
        bus.tag_i     = 5'd11;
        @(negedge clock);
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_fill_ready got %b want 1", bus.in_ready); else passed++;
        next_cycle();
        bus.out_ready = 1'b1;
        bus.data      = 32'h7F800001;
        bus.tag_i     = 5'd12;
        @(negedge clock);
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); else passed++;
        checks++; if (bus.out_valid !== 1'b1 || bus.tag_o !== 5'd10) $display("FAIL b2b_out0 got valid %b tag %0d want valid 1 tag 10", bus.out_valid, bus.tag_o); else passed++;
        checks++; if (bus.result !== 32'h001) $display("FAIL b2b_res0 got %h want 00000001", bus.result); else passed++;
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b1 || bus.tag_o !== 5'd11) $display("FAIL b2b_out1 got valid %b tag %0d want valid 1 tag 11", bus.out_valid, bus.tag_o); else passed++;
        checks++; if (bus.result !== 32'h008) $display("FAIL b2b_res1 got %h want 00000008", bus.result); else passed++;
        next_cycle();
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b1 || bus.tag_o !== 5'd12) $display("FAIL b2b_out2 got valid %b tag %0d want valid 1 tag 12", bus.out_valid, bus.tag_o); else passed++;
        checks++; if (bus.result !== 32'h100) $display("FAIL b2b_res2 got %h want 00000100", bus.result); else passed++;
        next_cycle();
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got out_valid %b want 0", bus.out_valid); else passed++;
        next_cycle();
    endtask

    task automatic test_flush();
        drain();
        bus.out_ready = 1'b0;
        bus.fmt       = 2'd0;
        bus.in_valid  = 1'b1;
        bus.data      = 32'h3F800000;
        bus.tag_i     = 5'd20;
        next_cycle();
        bus.tag_i     = 5'd21;
        next_cycle();
        flush         = 1'b1;
        bus.tag_i     = 5'd22;
        @(negedge clock);
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", bus.in_ready); else passed++;
        next_cycle();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL flush_ready_after got %b want 1", bus.in_ready); else passed++;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clock);
            checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_ghost[%0d] got out_valid %b tag %0d want 0", k, bus.out_valid, bus.tag_o); else passed++;
        end
        next_cycle();
        bus.in_valid = 1'b1;
        bus.data     = 32'h807FFFFF;
        bus.tag_i    = 5'd23;
        next_cycle();
        bus.in_valid = 1'b0;
        next_cycle();
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b1 || bus.tag_o !== 5'd23) $display("FAIL flush_recover got valid %b tag %0d want valid 1 tag 23", bus.out_valid, bus.tag_o); else passed++;
        checks++; if (bus.result !== 32'h004) $display("FAIL flush_recover_res got %h want 00000004", bus.result); else passed++;
        next_cycle();
    endtask

    task automatic test_reset_midstream();
        drain();
        bus.out_ready = 1'b1;
        bus.fmt       = 2'd0;
        bus.in_valid  = 1'b1;
        bus.data      = 32'h3F800000;
        bus.tag_i     = 5'd3;
        next_cycle();
        bus.tag_i     = 5'd4;
        next_cycle();
        bus.tag_i     = 5'd5;
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b1 || bus.tag_o !== 5'd3) $display("FAIL mrst_pre got valid %b tag %0d want valid 1 tag 3", bus.out_valid, bus.tag_o); else passed++;
        #2;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL mrst_out_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.result !== 32'h0) $display("FAIL mrst_result got %h want 00000000", bus.result); else passed++;
        checks++; if (bus.tag_o !== 5'd0) $display("FAIL mrst_tag got %0d want 0", bus.tag_o); else passed++;
        next_cycle();
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.data     = 32'h00000001;
        bus.tag_i    = 5'd9;
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL mrst_stale0 got out_valid %b want 0", bus.out_valid); else passed++;
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL mrst_stale1 got out_valid %b want 0", bus.out_valid); else passed++;
        next_cycle();
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b1 || bus.tag_o !== 5'd9) $display("FAIL mrst_new got valid %b tag %0d want valid 1 tag 9", bus.out_valid, bus.tag_o); else passed++;
        checks++; if (bus.result !== 32'h020) $display("FAIL mrst_new_res got %h want 00000020", bus.result); else passed++;
        next_cycle();
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data      = 32'h0;
        bus.fmt       = 2'd0;
        bus.tag_i     = 5'd0;
        bus.out_ready = 1'b1;
        test_reset();
        test_classes();
        test_fmt();
        test_back_pressure();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
